// File: rtl/video_pattern_src.sv
// Raster timing generator with selectable RGB888 test patterns (bars, grid, grey ramp, solid).
// Optional post_hs output is enabled by defining VIDEO_SRC_HS_EN.
module video_pattern_src #(
  parameter logic [11:0] IMG_HDISP = 12'd1280,
  parameter logic [11:0] IMG_VDISP = 12'd720,
  parameter logic [11:0] H_FP      = 12'd110,
  parameter logic [11:0] H_SYNC    = 12'd40,
  parameter logic [11:0] H_BP      = 12'd220,
  parameter logic [11:0] V_FP      = 12'd5,
  parameter logic [11:0] V_SYNC    = 12'd5,
  parameter logic [11:0] V_BP      = 12'd20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern,
  input  logic [23:0] solid_color,
  output logic        post_vs,
  output logic        post_de,
  output logic [23:0] post_data,
  output logic        frame_start
`ifdef VIDEO_SRC_HS_EN
  ,
  output logic        post_hs
`endif
);

  localparam logic [11:0] H_TOTAL = IMG_HDISP + H_FP + H_SYNC + H_BP;
  localparam logic [11:0] V_TOTAL = IMG_VDISP + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_SS    = IMG_HDISP + H_FP;
  localparam logic [11:0] H_SE    = H_SS + H_SYNC;
  localparam logic [11:0] V_SS    = IMG_VDISP + V_FP;
  localparam logic [11:0] V_SE    = V_SS + V_SYNC;
  localparam logic [11:0] BAR_W   = IMG_HDISP >> 3;

  logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [11:0] bar_pix_q, bar_pix_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [1:0]  pat_q, pat_d;
  logic [23:0] solid_q, solid_d;
  logic        de_q, de_d, vs_q, vs_d, fs_q, fs_d, hs_q, hs_d;
  logic [23:0] data_q, data_d;

  logic        first_px, active, h_wrap;
  logic [1:0]  pat_cur;
  logic [23:0] solid_cur, bar_color, color;

  always_comb begin
    first_px  = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
    active    = (hcnt_q < IMG_HDISP) && (vcnt_q < IMG_VDISP);
    h_wrap    = (hcnt_q == H_TOTAL - 12'd1);
    // The frame's first pixel already uses the newly latched selection.
    pat_cur   = first_px ? pattern : pat_q;
    solid_cur = first_px ? solid_color : solid_q;

    case (bar_idx_q)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase

    case (pat_cur)
      2'b00:   color = bar_color;
      2'b01:   color = ((hcnt_q[4:0] == 5'd0) || (vcnt_q[4:0] == 5'd0)) ? 24'hFFFFFF : 24'h000000;
      2'b10:   color = {hcnt_q[7:0], hcnt_q[7:0], hcnt_q[7:0]};
      default: color = solid_cur;
    endcase

    hcnt_d    = 12'd0;
    vcnt_d    = 12'd0;
    bar_pix_d = 12'd0;
    bar_idx_d = 3'd0;
    pat_d     = pat_q;
    solid_d   = solid_q;
    de_d      = 1'b0;
    vs_d      = 1'b0;
    hs_d      = 1'b0;
    fs_d      = 1'b0;
    data_d    = 24'h000000;

    if (en) begin
      if (first_px) begin
        pat_d   = pattern;
        solid_d = solid_color;
      end
      de_d   = active;
      vs_d   = (vcnt_q >= V_SS) && (vcnt_q < V_SE);
      hs_d   = (hcnt_q >= H_SS) && (hcnt_q < H_SE);
      fs_d   = first_px;
      data_d = active ? color : 24'h000000;

      if (h_wrap) begin
        hcnt_d = 12'd0;
        vcnt_d = (vcnt_q == V_TOTAL - 12'd1) ? 12'd0 : vcnt_q + 12'd1;
      end else begin
        hcnt_d = hcnt_q + 12'd1;
        vcnt_d = vcnt_q;
        // Bar position tracks hcnt through the active span; it stays cleared on a new line.
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        if (hcnt_q < IMG_HDISP) begin
          if (bar_pix_q == BAR_W - 12'd1) begin
            bar_pix_d = 12'd0;
            bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_pix_d = bar_pix_q + 12'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q    <= 12'd0;
      vcnt_q    <= 12'd0;
      bar_pix_q <= 12'd0;
      bar_idx_q <= 3'd0;
      pat_q     <= 2'b00;
      solid_q   <= 24'h000000;
      de_q      <= 1'b0;
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      fs_q      <= 1'b0;
      data_q    <= 24'h000000;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      solid_q   <= solid_d;
      de_q      <= de_d;
      vs_q      <= vs_d;
      hs_q      <= hs_d;
      fs_q      <= fs_d;
      data_q    <= data_d;
    end
  end

  assign post_de     = de_q;
  assign post_vs     = vs_q;
  assign post_data   = data_q;
  assign frame_start = fs_q;
`ifdef VIDEO_SRC_HS_EN
  assign post_hs     = hs_q;
`else
  logic unused_hs;
  assign unused_hs   = hs_q;
`endif

endmodule

// File: tb/tb_video_pattern_src.sv
// Bench for video_pattern_src on a 16x4 raster (22x7 total); per-cycle scoreboard plus
// scenario-level counts for timing, patterns, enable drop and asynchronous reset.
module tb_video_pattern_src;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  pattern;
  logic [23:0] solid_color;
  logic        post_vs, post_de, frame_start;
  logic [23:0] post_data;
`ifdef VIDEO_SRC_HS_EN
  logic        post_hs;
`endif

  always #5 clk = ~clk;

  video_pattern_src #(
    .IMG_HDISP(12'd16), .IMG_VDISP(12'd4),
    .H_FP(12'd2), .H_SYNC(12'd2), .H_BP(12'd2),
    .V_FP(12'd1), .V_SYNC(12'd1), .V_BP(12'd1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern(pattern), .solid_color(solid_color),
    .post_vs(post_vs), .post_de(post_de), .post_data(post_data), .frame_start(frame_start)
`ifdef VIDEO_SRC_HS_EN
    , .post_hs(post_hs)
`endif
  );

  typedef struct packed {
    logic        de;
    logic        vs;
    logic        hs;
    logic        fs;
    logic [23:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference raster position and latched selection
  int          m_h = 0, m_v = 0;
  logic [1:0]  m_pat = 2'b00;
  logic [23:0] m_solid = 24'h0;
  exp_t        obs;

  function automatic logic [23:0] bar_ref(input int b);
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s = '0;
    s.de = post_de; s.vs = post_vs; s.fs = frame_start; s.data = post_data;
`ifdef VIDEO_SRC_HS_EN
    s.hs = post_hs;
`endif
    return s;
  endfunction

  // One clock: predict from the current inputs, push, clock, pop and compare.
  task automatic step();
    exp_t e, got;
    logic [7:0] g;
    e = '0;
    if (en) begin
      if (m_h == 0 && m_v == 0) begin
        m_pat = pattern;
        m_solid = solid_color;
      end
      e.de = (m_h < 16) && (m_v < 4);
      e.vs = (m_v == 5);
`ifdef VIDEO_SRC_HS_EN
      e.hs = (m_h >= 18) && (m_h < 20);
`endif
      e.fs = (m_h == 0) && (m_v == 0);
      if (e.de) begin
        g = 8'(m_h % 256);
        case (m_pat)
          2'b00: e.data = bar_ref(m_h / 2);
          2'b01: e.data = ((m_h % 32 == 0) || (m_v % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
          2'b10: e.data = {g, g, g};
          default: e.data = m_solid;
        endcase
      end
      if (m_h == 21) begin
        m_h = 0;
        m_v = (m_v == 6) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end else begin
      m_h = 0;
      m_v = 0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got = sample();
    obs = got;
    cyc++;
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL pixel cyc=%0d got de=%b vs=%b hs=%b fs=%b data=%h expected de=%b vs=%b hs=%b fs=%b data=%h",
               cyc, got.de, got.vs, got.hs, got.fs, got.data, e.de, e.vs, e.hs, e.fs, e.data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; pattern = 2'b00; solid_color = 24'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sample() !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", sample());
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    $display("reset: outputs idle, en=0 holds idle");
  endtask

  task automatic test_timing();
    int fs_cnt, de_cnt, first_fs, second_fs;
    fs_cnt = 0; de_cnt = 0; first_fs = -1; second_fs = -1;
    en = 1'b1; pattern = 2'b00;
    for (int i = 0; i < 308; i++) begin
      step();
      if (obs.fs) begin
        if (fs_cnt == 0) first_fs = i; else second_fs = i;
        fs_cnt++;
      end
      if (obs.de) de_cnt++;
    end
    checks++;
    if (first_fs !== 0) begin errors++; $display("FAIL first_frame_start got %0d expected 0", first_fs); end
    checks++;
    if (second_fs - first_fs !== 154) begin
      errors++; $display("FAIL frame_period got %0d expected 154", second_fs - first_fs);
    end
    checks++;
    if (de_cnt !== 128) begin errors++; $display("FAIL de_count got %0d expected 128", de_cnt); end
    $display("timing: fs at %0d and %0d, de cycles %0d", first_fs, second_fs, de_cnt);
  endtask

  task automatic test_vsync();
    int vs_cnt, vs_first;
    vs_cnt = 0; vs_first = -1;
    for (int i = 0; i < 154; i++) begin
      step();
      if (obs.vs) begin
        if (vs_first < 0) vs_first = i;
        vs_cnt++;
      end
    end
    checks++;
    if (vs_cnt !== 22) begin errors++; $display("FAIL vs_width got %0d expected 22", vs_cnt); end
    checks++;
    if (vs_first !== 110) begin errors++; $display("FAIL vs_start got %0d expected 110", vs_first); end
    $display("vsync: %0d cycles starting at offset %0d", vs_cnt, vs_first);
  endtask

  task automatic test_pattern_switch();
    int solid_cnt;
    repeat (30) step();
    pattern = 2'b11; solid_color = 24'h123456;
    solid_cnt = 0;
    repeat (124) begin step(); if (obs.de && obs.data == 24'h123456) solid_cnt++; end
    checks++;
    if (solid_cnt !== 0) begin errors++; $display("FAIL switch_current_frame got %0d solid expected 0", solid_cnt); end
    solid_cnt = 0;
    repeat (154) begin step(); if (obs.de && obs.data == 24'h123456) solid_cnt++; end
    checks++;
    if (solid_cnt !== 64) begin errors++; $display("FAIL switch_next_frame got %0d solid expected 64", solid_cnt); end
    $display("pattern switch: next frame solid pixels %0d", solid_cnt);
  endtask

  task automatic test_grid_ramp();
    pattern = 2'b01;
    repeat (154) step();
    pattern = 2'b10;
    repeat (154) step();
    $display("grid and ramp frames compared");
  endtask

  task automatic test_en_drop();
    int guard;
    pattern = 2'b00;
    guard = 0;
    while (!(m_h == 5 && m_v == 2) && guard < 400) begin step(); guard++; end
    checks++;
    if (guard >= 400) begin errors++; $display("FAIL en_drop_position got timeout expected line 2 pixel 5"); end
    en = 1'b0;
    repeat (3) step();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL en_drop_idle got %h expected 0", obs); end
    en = 1'b1;
    step();
    checks++;
    if (obs.fs !== 1'b1) begin errors++; $display("FAIL reenable_fs got %b expected 1", obs.fs); end
    repeat (160) step();
    $display("en drop: idle while low, fresh frame on re-enable");
  endtask

  task automatic test_async_reset();
    repeat (40) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sample() !== '0) begin errors++; $display("FAIL async_reset got %h expected 0", sample()); end
    m_h = 0; m_v = 0; m_pat = 2'b00; m_solid = 24'h0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; pattern = 2'b00;
    step();
    checks++;
    if (obs.fs !== 1'b1 || obs.data !== 24'hFFFFFF) begin
      errors++; $display("FAIL restart_after_reset got fs=%b data=%h expected fs=1 data=ffffff", obs.fs, obs.data);
    end
    repeat (153) step();
    $display("async reset: outputs cleared, frame restarted");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timing();
    test_vsync();
    test_pattern_switch();
    test_grid_ramp();
    test_en_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
